avalon_xbar: RTL and testbench
==============================

AVALON_XBAR -- requirements
Module: avalon_xbar

Interface
REQ-001 SHALL have parameter NUM_MASTER, default 3, number of Avalon masters (range 1..8).
REQ-002 SHALL have parameter NUM_SLAVE, default 6, number of Avalon slaves (range 1..16).
REQ-003 SHALL have parameter SLV_BASE, default all-zero, packed NUM_SLAVE*32 bits, slave i base address in bits [32i+31:32i].
REQ-004 SHALL have parameter SLV_MASK, default all-zero, packed NUM_SLAVE*32 bits, slave i compare mask.
REQ-005 SHALL have parameter ARB_MODE, default 0; 0 = round-robin, 1 = fixed priority with master 0 highest.
REQ-006 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports m_read and m_write, input, NUM_MASTER, per-master request strobes.
REQ-009 SHALL have ports m_address and m_writedata, input, NUM_MASTER*32, plus m_byte_enable, input, NUM_MASTER*4.
REQ-010 SHALL have ports m_readdata, output, NUM_MASTER*32, and m_waitrequest, output, NUM_MASTER.
REQ-011 SHALL have ports s_read and s_write, output, NUM_SLAVE; s_address and s_writedata, output, NUM_SLAVE*32; s_byte_enable, output, NUM_SLAVE*4.
REQ-012 SHALL have ports s_readdata, input, NUM_SLAVE*32, and s_waitrequest, input, NUM_SLAVE.
REQ-013 SHALL have port decode_err, output, NUM_MASTER, one-cycle pulse per unmapped access.

Function
REQ-014 Decode: master m hits slave i when (m_address & SLV_MASK[i]) == SLV_BASE[i]; the lowest-index hit wins; no hit = unmapped.
REQ-015 Each slave SHALL own an independent arbiter: states IDLE and LOCKED, a one-hot grant register (NUM_MASTER bits) and a round-robin pointer.
REQ-016 IDLE: winner chosen combinationally among requesters (m_read|m_write) hitting that slave; the winner's request is forwarded to the slave in the same cycle (zero added latency).
REQ-017 IDLE -> LOCKED when a winner exists and s_waitrequest=1; the winner is registered in grant.
REQ-018 LOCKED: only the granted master is forwarded; the arbiter SHALL NOT re-arbitrate until s_waitrequest=0.
REQ-019 Completion = forwarded request with s_waitrequest=0; the arbiter returns to IDLE, and in round-robin mode the pointer = winner index + 1 modulo NUM_MASTER.
REQ-020 Round-robin search SHALL start at the pointer; ARB_MODE=1 ignores the pointer.
REQ-021 Non-forwarded requesting masters SHALL see m_waitrequest=1; a non-requesting master SHALL see m_waitrequest=0.
REQ-022 m_readdata of a forwarded master SHALL equal s_readdata of its slave in the same cycle; otherwise it SHALL be 0.
REQ-023 Unforwarded slaves SHALL see s_read=s_write=0; s_address, s_writedata and s_byte_enable SHALL be 0.
REQ-024 If the granted master drops its request while LOCKED, the arbiter SHALL return to IDLE with the pointer unchanged (protocol violation, no transfer).
REQ-025 Different slaves SHALL serve different masters concurrently in the same cycle.

Reset
REQ-026 rst SHALL asynchronously clear all grants to 0, set all states to IDLE and all pointers to 0.
REQ-027 While rst=1: s_read=s_write=0, m_waitrequest all 1, m_readdata all 0, decode_err all 0; in-flight transfers SHALL be abandoned.

Configuration
REQ-028 Macro AVALON_XBAR_DECODE_ERR_EN defined: an unmapped access SHALL complete in the same cycle with m_waitrequest=0, m_readdata=32'hDEADBEEF and decode_err[m]=1 for that cycle.
REQ-029 Macro absent: an unmapped access SHALL complete in the same cycle with m_readdata=0; decode_err SHALL be tied to 0.

Structure
REQ-030 ARB_MODE encodings, the 32'hDEADBEEF constant and the avalon_req_t/avalon_resp_t typedefs SHALL live in the shared SoC package.
REQ-031 The per-slave arbiter SHALL be sub-module avalon_xbar_arb (parameter NUM_MASTER, ARB_MODE), instantiated NUM_SLAVE times via generate.

Verification
REQ-032 Single master reads slave 2 (base 0x2000_0000, mask 0xF000_0000) at 0x2000_0010, s_waitrequest=0 -> s_read[2]=1 same cycle, m_readdata=s_readdata, m_waitrequest=0.
REQ-033 Masters 0, 1 and 2 write continuously to slave 0, zero-wait -> grants rotate 0,1,2,0 across cycles in round-robin mode; 0,0,0 with ARB_MODE=1.
REQ-034 Slave holds s_waitrequest=1 for 3 cycles on master 1 -> grant stays 1 and master 2 sees m_waitrequest=1 for 4 cycles, then master 2 is served.
REQ-035 Masters 0 and 1 access slaves 0 and 3 in the same cycle -> both complete in that cycle.
REQ-036 Read of 0xF000_0000 with no mapping -> with macro: readdata 0xDEADBEEF, decode_err pulse; without macro: readdata 0, no pulse.
REQ-037 Assert rst during a LOCKED transfer -> s_read drops immediately; after release, a new request from master 0 is granted first.

Source files
------------

// File: rtl/avalon_xbar_pkg.sv
// Shared SoC definitions for the Avalon crossbar: arbitration encodings, the
// decode-error read pattern, request/response bundles and the round-robin step.
package avalon_xbar_pkg;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  localparam logic [31:0] DECODE_ERR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
  } avalon_resp_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/avalon_xbar_arb.sv
// Per-slave arbiter: picks a master combinationally when idle and locks the grant
// while the slave stalls, so a stalled transfer is never re-arbitrated.
module avalon_xbar_arb
  import avalon_xbar_pkg::*;
#(
  parameter int unsigned NUM_MASTER = 3,
  parameter int unsigned ARB_MODE   = ARB_RR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_MASTER-1:0] req,
  input  logic                  s_waitrequest,
  output logic [NUM_MASTER-1:0] sel
);

  localparam int unsigned PW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;

  typedef enum logic {StIdle, StLocked} state_t;

  state_t                state;
  logic [NUM_MASTER-1:0] grant;
  logic [NUM_MASTER-1:0] winner;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         gnt_idx;
  logic                  found;

  always_comb begin
    int unsigned idx;
    winner  = '0;
    win_idx = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_MASTER; k++) begin
      idx = (ARB_MODE == ARB_FIXED) ? k : (32'(ptr) + k) % NUM_MASTER;
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        win_idx     = PW'(idx);
      end
    end
    for (int unsigned k = 0; k < NUM_MASTER; k++) begin
      if (grant[k]) gnt_idx = PW'(k);
    end
    // A locked grant whose master dropped its request forwards nothing.
    sel = (state == StLocked) ? (grant & req) : winner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
      grant <= '0;
      ptr   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (found) begin
            if (s_waitrequest) begin
              state <= StLocked;
              grant <= winner;
            end else if (ARB_MODE == ARB_RR) begin
              ptr <= PW'(rr_next(32'(win_idx), NUM_MASTER));
            end
          end
        end
        StLocked: begin
          if (~|(grant & req)) begin
            state <= StIdle;
            grant <= '0;
          end else if (!s_waitrequest) begin
            state <= StIdle;
            grant <= '0;
            if (ARB_MODE == ARB_RR) ptr <= PW'(rr_next(32'(gnt_idx), NUM_MASTER));
          end
        end
        default: begin
          state <= StIdle;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/avalon_xbar.sv
// Avalon-MM crossbar with address decode and one arbiter per slave.
// AVALON_XBAR_DECODE_ERR_EN: unmapped accesses return DEADBEEF and pulse decode_err.
module avalon_xbar
  import avalon_xbar_pkg::*;
#(
  parameter int unsigned             NUM_MASTER = 3,
  parameter int unsigned             NUM_SLAVE  = 6,
  parameter logic [NUM_SLAVE*32-1:0] SLV_BASE   = '0,
  parameter logic [NUM_SLAVE*32-1:0] SLV_MASK   = '0,
  parameter int unsigned             ARB_MODE   = ARB_RR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_MASTER-1:0]   m_read,
  input  logic [NUM_MASTER-1:0]   m_write,
  input  logic [NUM_MASTER*32-1:0] m_address,
  input  logic [NUM_MASTER*32-1:0] m_writedata,
  input  logic [NUM_MASTER*4-1:0] m_byte_enable,
  output logic [NUM_MASTER*32-1:0] m_readdata,
  output logic [NUM_MASTER-1:0]   m_waitrequest,
  output logic [NUM_SLAVE-1:0]    s_read,
  output logic [NUM_SLAVE-1:0]    s_write,
  output logic [NUM_SLAVE*32-1:0] s_address,
  output logic [NUM_SLAVE*32-1:0] s_writedata,
  output logic [NUM_SLAVE*4-1:0]  s_byte_enable,
  input  logic [NUM_SLAVE*32-1:0] s_readdata,
  input  logic [NUM_SLAVE-1:0]    s_waitrequest,
  output logic [NUM_MASTER-1:0]   decode_err
);

  localparam int unsigned SW = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1;

  avalon_req_t           mreq    [NUM_MASTER];
  avalon_resp_t          mresp   [NUM_MASTER];
  logic [NUM_MASTER-1:0] req;
  logic [NUM_MASTER-1:0] mapped;
  logic [SW-1:0]         hit_idx [NUM_MASTER];
  logic [NUM_MASTER-1:0] slv_req [NUM_SLAVE];
  logic [NUM_MASTER-1:0] sel     [NUM_SLAVE];
  logic [NUM_MASTER-1:0] fwd;

  // Scan slaves from the top down so the lowest-index hit is the one kept.
  always_comb begin
    for (int m = 0; m < NUM_MASTER; m++) begin
      mreq[m] = '{read:        m_read[m],
                  write:       m_write[m],
                  address:     m_address[m*32 +: 32],
                  writedata:   m_writedata[m*32 +: 32],
                  byte_enable: m_byte_enable[m*4 +: 4]};
      req[m]     = m_read[m] | m_write[m];
      mapped[m]  = 1'b0;
      hit_idx[m] = '0;
      for (int i = int'(NUM_SLAVE) - 1; i >= 0; i--) begin
        if ((mreq[m].address & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
          mapped[m]  = 1'b1;
          hit_idx[m] = SW'(i);
        end
      end
    end
    for (int i = 0; i < NUM_SLAVE; i++) begin
      for (int m = 0; m < NUM_MASTER; m++) begin
        slv_req[i][m] = req[m] & mapped[m] & (hit_idx[m] == SW'(i));
      end
    end
  end

  for (genvar i = 0; i < NUM_SLAVE; i++) begin : g_arb
    avalon_xbar_arb #(
      .NUM_MASTER(NUM_MASTER),
      .ARB_MODE  (ARB_MODE)
    ) u_arb (
      .clk          (clk),
      .rst          (rst),
      .req          (slv_req[i]),
      .s_waitrequest(s_waitrequest[i]),
      .sel          (sel[i])
    );
  end

  always_comb begin
    s_read        = '0;
    s_write       = '0;
    s_address     = '0;
    s_writedata   = '0;
    s_byte_enable = '0;
    decode_err    = '0;
    fwd           = '0;
    for (int m = 0; m < NUM_MASTER; m++) begin
      mresp[m] = '{readdata: 32'h0, waitrequest: rst};
    end
    if (!rst) begin
      for (int i = 0; i < NUM_SLAVE; i++) begin
        for (int m = 0; m < NUM_MASTER; m++) begin
          if (sel[i][m]) begin
            s_read[i]               = mreq[m].read;
            s_write[i]              = mreq[m].write;
            s_address[i*32 +: 32]   = mreq[m].address;
            s_writedata[i*32 +: 32] = mreq[m].writedata;
            s_byte_enable[i*4 +: 4] = mreq[m].byte_enable;
            mresp[m].readdata       = s_readdata[i*32 +: 32];
            mresp[m].waitrequest    = s_waitrequest[i];
            fwd[m]                  = 1'b1;
          end
        end
      end
      for (int m = 0; m < NUM_MASTER; m++) begin
        if (req[m] && !fwd[m]) begin
          if (mapped[m]) mresp[m].waitrequest = 1'b1;
`ifdef AVALON_XBAR_DECODE_ERR_EN
          else begin
            mresp[m].readdata = DECODE_ERR_DATA;
            decode_err[m]     = 1'b1;
          end
`endif
        end
      end
    end
  end

  always_comb begin
    for (int m = 0; m < NUM_MASTER; m++) begin
      m_readdata[m*32 +: 32] = mresp[m].readdata;
      m_waitrequest[m]       = mresp[m].waitrequest;
    end
  end

endmodule

// File: tb/tb_avalon_xbar.sv
// Bench for avalon_xbar: a round-robin and a fixed-priority instance share stimulus
// and are checked every cycle against a transaction-level reference model.
module tb_avalon_xbar;

  localparam int NM = 3;
  localparam int NS = 6;
  // Slaves 0..4 own one 256 MiB window each; slave 5 overlaps slave 4 (0x4/0x5).
  localparam logic [NS*32-1:0] BASE = {32'h4000_0000, 32'h4000_0000, 32'h3000_0000,
                                       32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK = {32'hE000_0000, {5{32'hF000_0000}}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_read, m_write;
  logic [NM*32-1:0] m_address, m_writedata;
  logic [NM*4-1:0]  m_be;
  logic [NS*32-1:0] s_readdata;
  logic [NS-1:0]    s_wait;

  logic [NM*32-1:0] m_rdata [2];
  logic [NM-1:0]    m_wait  [2];
  logic [NM-1:0]    derr    [2];
  logic [NS-1:0]    s_rd    [2];
  logic [NS-1:0]    s_wr    [2];
  logic [NS*32-1:0] s_addr  [2];
  logic [NS*32-1:0] s_wdata [2];
  logic [NS*4-1:0]  s_be    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    avalon_xbar #(
      .NUM_MASTER(NM),
      .NUM_SLAVE (NS),
      .SLV_BASE  (BASE),
      .SLV_MASK  (MASK),
      .ARB_MODE  (g)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .m_read       (m_read),
      .m_write      (m_write),
      .m_address    (m_address),
      .m_writedata  (m_writedata),
      .m_byte_enable(m_be),
      .m_readdata   (m_rdata[g]),
      .m_waitrequest(m_wait[g]),
      .s_read       (s_rd[g]),
      .s_write      (s_wr[g]),
      .s_address    (s_addr[g]),
      .s_writedata  (s_wdata[g]),
      .s_byte_enable(s_be[g]),
      .s_readdata   (s_readdata),
      .s_waitrequest(s_wait),
      .decode_err   (derr[g])
    );
  end

  int compared   = 0;
  int mismatched = 0;
  int owner [2][NS];  // master holding a stalled slave, -1 when free
  int ptr   [2][NS];  // next master to favour (round-robin instance only)

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr(input int m);
    return m_address[m*32 +: 32];
  endfunction

  function automatic logic rq(input int m);
    return m_read[m] | m_write[m];
  endfunction

  // Address map as arithmetic on the top nibble: 0..5 map to that slave, else unmapped.
  function automatic int dec(input logic [31:0] a);
    int n;
    n = int'(a[31:28]);
    return (n <= 5) ? n : -1;
  endfunction

  task automatic drive(input int m, input logic rd, input logic wr, input logic [31:0] a);
    m_read[m]              = rd;
    m_write[m]             = wr;
    m_address[m*32 +: 32]  = a;
    m_writedata[m*32 +: 32] = $urandom;
    m_be[m*4 +: 4]         = 4'($urandom);
  endtask

  task automatic idle();
    m_read  = '0;
    m_write = '0;
  endtask

  // Compare both instances against the model for the current cycle, then advance.
  task automatic step();
    #1;
    for (int md = 0; md < 2; md++) begin
      logic [NS-1:0]    ers, ews;
      logic [NS*32-1:0] ea, ewd;
      logic [NS*4-1:0]  ebe;
      logic [NM*32-1:0] erd;
      logic [NM-1:0]    ewait, ederr, got;
      int               f [NS];
      string            nm;
      nm = (md == 1) ? "fp" : "rr";
      ers = '0; ews = '0; ea = '0; ewd = '0; ebe = '0;
      erd = '0; ewait = '0; ederr = '0; got = '0;
      for (int s = 0; s < NS; s++) f[s] = -1;
      if (rst) begin
        ewait = '1;
      end else begin
        for (int s = 0; s < NS; s++) begin
          if (owner[md][s] >= 0) begin
            if (rq(owner[md][s]) && dec(addr(owner[md][s])) == s) f[s] = owner[md][s];
          end else begin
            for (int k = 0; k < NM; k++) begin
              int m;
              m = (md == 1) ? k : (ptr[md][s] + k) % NM;
              if (f[s] < 0 && rq(m) && dec(addr(m)) == s) f[s] = m;
            end
          end
          if (f[s] >= 0) begin
            ers[s]           = m_read[f[s]];
            ews[s]           = m_write[f[s]];
            ea[s*32 +: 32]   = addr(f[s]);
            ewd[s*32 +: 32]  = m_writedata[f[s]*32 +: 32];
            ebe[s*4 +: 4]    = m_be[f[s]*4 +: 4];
            erd[f[s]*32 +: 32] = s_readdata[s*32 +: 32];
            ewait[f[s]]      = s_wait[s];
            got[f[s]]        = 1'b1;
          end
        end
        for (int m = 0; m < NM; m++) begin
          if (rq(m) && !got[m]) begin
            if (dec(addr(m)) >= 0) ewait[m] = 1'b1;
`ifdef AVALON_XBAR_DECODE_ERR_EN
            else begin
              erd[m*32 +: 32] = 32'hDEADBEEF;
              ederr[m]        = 1'b1;
            end
`endif
          end
        end
      end
      chk({nm, ".s_read"}, 192'(s_rd[md]), 192'(ers));
      chk({nm, ".s_write"}, 192'(s_wr[md]), 192'(ews));
      chk({nm, ".m_waitrequest"}, 192'(m_wait[md]), 192'(ewait));
      chk({nm, ".m_readdata"}, 192'(m_rdata[md]), 192'(erd));
      chk({nm, ".decode_err"}, 192'(derr[md]), 192'(ederr));
      if (!rst) begin
        chk({nm, ".s_address"}, 192'(s_addr[md]), 192'(ea));
        chk({nm, ".s_writedata"}, 192'(s_wdata[md]), 192'(ewd));
        chk({nm, ".s_byte_enable"}, 192'(s_be[md]), 192'(ebe));
      end
      for (int s = 0; s < NS; s++) begin
        if (rst) begin
          owner[md][s] = -1;
          ptr[md][s]   = 0;
        end else if (owner[md][s] >= 0 && f[s] < 0) begin
          owner[md][s] = -1;
        end else if (f[s] >= 0) begin
          if (s_wait[s]) begin
            owner[md][s] = f[s];
          end else begin
            owner[md][s] = -1;
            if (md == 0) ptr[md][s] = (f[s] + 1) % NM;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int          rr_seq [4];
    logic [NM-1:0] e;
    rr_seq = '{0, 1, 2, 0};
    for (int md = 0; md < 2; md++)
      for (int s = 0; s < NS; s++) begin
        owner[md][s] = -1;
        ptr[md][s]   = 0;
      end
    m_read = '0; m_write = '0; m_address = '0; m_writedata = '0; m_be = '0;
    s_readdata = '0; s_wait = '0;
    drive(0, 1'b1, 1'b0, 32'h0000_0004);  // request held during reset
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    idle();
    step();

    // Single read of slave 2, zero wait.
    drive(0, 1'b1, 1'b0, 32'h2000_0010);
    s_readdata[2*32 +: 32] = 32'h1234_5678;
    #1;
    chk("single.s_read2", 192'(s_rd[0][2]), 192'(1'b1));
    chk("single.readdata", 192'(m_rdata[0][31:0]), 192'(32'h1234_5678));
    chk("single.wait", 192'(m_wait[0][0]), 192'(1'b0));
    step();

    // Three masters stream writes to slave 0.
    for (int c = 0; c < 4; c++) begin
      for (int m = 0; m < NM; m++) drive(m, 1'b0, 1'b1, 32'h0000_0100 + 32'(m));
      #1;
      e = '1;
      e[rr_seq[c]] = 1'b0;
      chk("rr.rotation", 192'(m_wait[0]), 192'(e));
      chk("fp.priority", 192'(m_wait[1]), 192'(3'b110));
      step();
    end

    // Master 1 stalled three cycles; master 2 must wait through completion.
    idle();
    drive(1, 1'b0, 1'b1, 32'h0000_0200);
    drive(2, 1'b0, 1'b1, 32'h0000_0300);
    s_wait[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("lock.m1_stall", 192'(m_wait[0][1]), 192'(1'b1));
      chk("lock.m2_wait", 192'(m_wait[0][2]), 192'(1'b1));
      step();
    end
    s_wait[0] = 1'b0;
    #1;
    chk("lock.m1_done", 192'(m_wait[0][1]), 192'(1'b0));
    chk("lock.m2_wait4", 192'(m_wait[0][2]), 192'(1'b1));
    step();
    m_write[1] = 1'b0;
    #1;
    chk("lock.m2_served", 192'(m_wait[0][2]), 192'(1'b0));
    step();

    // Concurrent service of two slaves, plus the overlapping window.
    idle();
    drive(0, 1'b1, 1'b0, 32'h0000_0040);
    drive(1, 1'b0, 1'b1, 32'h3000_0000);
    drive(2, 1'b1, 1'b0, 32'h4000_0008);
    #1;
    chk("concur.waits", 192'(m_wait[0]), 192'(3'b000));
    chk("concur.slaves", 192'(s_rd[0] | s_wr[0]), 192'(6'b011001));
    step();

    // Unmapped read.
    idle();
    drive(2, 1'b1, 1'b0, 32'hF000_0000);
    #1;
`ifdef AVALON_XBAR_DECODE_ERR_EN
    chk("unmapped.readdata", 192'(m_rdata[0][95:64]), 192'(32'hDEADBEEF));
    chk("unmapped.decode_err", 192'(derr[0]), 192'(3'b100));
`else
    chk("unmapped.readdata", 192'(m_rdata[0][95:64]), 192'(32'h0));
    chk("unmapped.decode_err", 192'(derr[0]), 192'(3'b000));
`endif
    chk("unmapped.wait", 192'(m_wait[0][2]), 192'(1'b0));
    step();

    // Granted master abandons a stalled request.
    idle();
    drive(1, 1'b0, 1'b1, 32'h1000_0000);
    s_wait[1] = 1'b1;
    step();
    idle();
    drive(0, 1'b1, 1'b0, 32'h1000_0004);
    step();
    s_wait[1] = 1'b0;
    step();

    // Reset during a locked transfer.
    idle();
    drive(0, 1'b1, 1'b0, 32'h4000_0000);
    s_wait[4] = 1'b0;
    step();
    idle();
    drive(2, 1'b1, 1'b0, 32'h4000_0004);
    s_wait[4] = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rst.s_read_drop", 192'(s_rd[0][4] | s_rd[1][4]), 192'(1'b0));
    step();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h4000_0010);
    drive(1, 1'b1, 1'b0, 32'h4000_0020);
    s_wait[4] = 1'b0;
    #1;
    chk("rst.m0_first", 192'(m_wait[0][1:0]), 192'(2'b10));
    step();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < NM; m++) begin
        if ($urandom_range(0, 9) < 4) begin
          int n, op;
          n  = $urandom_range(0, 7);
          op = $urandom_range(0, 2);
          drive(m, op == 1, op == 2, {(n == 7) ? 4'hF : 4'(n), 28'($urandom)});
        end
      end
      for (int s = 0; s < NS; s++) begin
        s_readdata[s*32 +: 32] = $urandom;
        s_wait[s]              = ($urandom_range(0, 9) < 3);
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
